// File: rtl/mux8_pkg.sv
// Shared types, sizes and the round-robin pick function for the 8-way mux arbiter.
package mux8_pkg;
  localparam int NREQ = 8;
  localparam int SELW = 3;

  typedef enum logic [1:0] {IDLE, XFER, WAIT} state_t;

  // First requester at or after ptr, circularly. Scanning downward lets the
  // smallest offset win without an early exit.
  function automatic logic [SELW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [SELW-1:0] ptr);
    logic [SELW:0]   idx;
    logic [SELW-1:0] pick;
    pick = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SELW+1)'(k);
      if (req[idx[SELW-1:0]]) pick = idx[SELW-1:0];
    end
    return pick;
  endfunction
endpackage

// File: rtl/mux8_core.sv
// Shared combinational 8:1 datapath mux.
module mux8_core
  import mux8_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [SELW-1:0]             sel,
  input  logic [NREQ-1:0][WIDTH-1:0]  d,
  output logic [WIDTH-1:0]            y
);
  assign y = d[sel];
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sequencing eight requesters through one shared 8:1 mux,
// with a registered valid/ready output.
module mux8_rr_arbiter
  import mux8_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0][WIDTH-1:0]  d,
  output logic [NREQ-1:0]             grant,
  output logic [SELW-1:0]             sel,
  output logic [WIDTH-1:0]            y,
  output logic                        out_valid,
  input  logic                        out_ready
);
  state_t          state, state_nxt;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] pick;
  logic [WIDTH-1:0] mux_y;

  assign pick = rr_pick(req, ptr);

  mux8_core #(.WIDTH(WIDTH)) u_core (
    .sel (sel),
    .d   (d),
    .y   (mux_y)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = XFER;
      XFER:    state_nxt = WAIT;
      WAIT:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // grant defaults low every cycle so it is a single-cycle pulse in XFER.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= '0;
      sel       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      grant <= '0;
      case (state)
        IDLE: if (|req) begin
          sel   <= pick;
          grant <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
        end
        XFER: begin
          y         <= mux_y;
          out_valid <= 1'b1;
        end
        WAIT: if (out_ready) begin
          out_valid <= 1'b0;
          ptr       <= sel + 3'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: reset, single request, round robin with
// wrap, backpressure, request drop and reset mid-transfer.
module tb_mux8_rr_arbiter;
  localparam int W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        req;
  logic [7:0][W-1:0] d;
  logic [7:0]        grant;
  logic [2:0]        sel;
  logic [W-1:0]      y;
  logic              out_valid;
  logic              out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mux8_rr_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .d         (d),
    .grant     (grant),
    .sel       (sel),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = W'(8'hA0 + i);
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) d[i] = W'(8'hA0 + i);
    tick(); tick();
    n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL reset_grant got %h want 00", grant); end
    n_checks++; if (sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", sel); end
    n_checks++; if (y !== 8'h00) begin n_fail++; $display("FAIL reset_y got %h want 00", y); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    reset = 1'b0;
    tick();
    n_checks++; if (grant !== 8'h01) begin n_fail++; $display("FAIL reset_first_grant got %h want 01", grant); end
    req = 8'h00;
    tick();
    n_checks++; if (out_valid !== 1'b1 || y !== 8'hA0) begin n_fail++; $display("FAIL reset_first_word got v=%b y=%h want v=1 y=a0", out_valid, y); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_first_done got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    do_reset();
    d[5] = 8'h01; req = 8'b0010_0000; out_ready = 1'b1;
    tick();
    n_checks++; if (grant !== 8'b0010_0000 || sel !== 3'd5) begin n_fail++; $display("FAIL single_grant got g=%h s=%0d want g=20 s=5", grant, sel); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early got %b want 0", out_valid); end
    req = 8'h00;
    tick();
    n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL single_grant_width got %h want 00", grant); end
    n_checks++; if (out_valid !== 1'b1 || y !== 8'h01 || sel !== 3'd5) begin n_fail++; $display("FAIL single_word got v=%b y=%h s=%0d want v=1 y=01 s=5", out_valid, y, sel); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_done got %b want 0", out_valid); end
    // ptr should now be 6: requester 6 wins over requester 0
    req = 8'b0100_0001;
    tick();
    n_checks++; if (grant !== 8'b0100_0000) begin n_fail++; $display("FAIL single_ptr6 got %h want 40", grant); end
    req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_round_robin();
    int exp_idx [4] = '{0, 1, 7, 0};
    logic [7:0] oh;
    do_reset();
    req = 8'b1000_0011; out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      oh = 8'h01 << exp_idx[j];
      tick();
      n_checks++; if (grant !== oh || sel !== 3'(exp_idx[j])) begin n_fail++; $display("FAIL rr_grant%0d got g=%h s=%0d want g=%h s=%0d", j, grant, sel, oh, exp_idx[j]); end
      tick();
      n_checks++; if (grant !== 8'h00 || out_valid !== 1'b1 || y !== W'(8'hA0 + exp_idx[j])) begin n_fail++; $display("FAIL rr_word%0d got g=%h v=%b y=%h want g=00 v=1 y=%h", j, grant, out_valid, y, 8'hA0 + exp_idx[j]); end
      tick();
      n_checks++; if (grant !== 8'h00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle%0d got g=%h v=%b want g=00 v=0", j, grant, out_valid); end
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 8'h18; out_ready = 1'b0;
    tick();
    n_checks++; if (grant !== 8'h08) begin n_fail++; $display("FAIL bp_grant got %h want 08", grant); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || y !== 8'hA3) begin n_fail++; $display("FAIL bp_word got v=%b y=%h want v=1 y=a3", out_valid, y); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || y !== 8'hA3 || sel !== 3'd3 || grant !== 8'h00) begin n_fail++; $display("FAIL bp_hold%0d got v=%b y=%h s=%0d g=%h want v=1 y=a3 s=3 g=00", k, out_valid, y, sel, grant); end
    end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || grant !== 8'h00) begin n_fail++; $display("FAIL bp_done got v=%b g=%h want v=0 g=00", out_valid, grant); end
    tick();
    n_checks++; if (grant !== 8'h10 || sel !== 3'd4) begin n_fail++; $display("FAIL bp_next_grant got g=%h s=%0d want g=10 s=4", grant, sel); end
    req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_req_drop();
    int gcount = 0;
    do_reset();
    req = 8'h08; out_ready = 1'b0;
    tick();
    gcount += $countones(grant);
    req = 8'h00;
    tick();
    gcount += $countones(grant);
    n_checks++; if (out_valid !== 1'b1 || y !== 8'hA3) begin n_fail++; $display("FAIL drop_word got v=%b y=%h want v=1 y=a3", out_valid, y); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      gcount += $countones(grant);
    end
    n_checks++; if (gcount != 1) begin n_fail++; $display("FAIL drop_grant_count got %0d want 1", gcount); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid_end got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h04; out_ready = 1'b0;
    tick();
    n_checks++; if (grant !== 8'h04) begin n_fail++; $display("FAIL rmid_grant got %h want 04", grant); end
    req = 8'h00;
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_valid got %b want 1", out_valid); end
    reset = 1'b1; out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || grant !== 8'h00 || sel !== 3'd0 || y !== 8'h00) begin n_fail++; $display("FAIL rmid_cleared got v=%b g=%h s=%0d y=%h want 0/00/0/00", out_valid, grant, sel, y); end
    reset = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0 || grant !== 8'h00) begin n_fail++; $display("FAIL rmid_no_replay got v=%b g=%h want v=0 g=00", out_valid, grant); end
    // ptr back at 0 picks requester 2; a stale ptr of 3 would pick requester 3
    req = 8'h0C;
    tick();
    n_checks++; if (grant !== 8'h04) begin n_fail++; $display("FAIL rmid_ptr0 got %h want 04", grant); end
    req = 8'h00;
    tick(); tick();
  endtask

  initial begin
    reset = 1'b1; req = '0; out_ready = 1'b0; d = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_req_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer that shares one 8:1 multiplexer datapath among eight requesters. It selects one pending requester, drives the mux select, registers the selected data word and presents it on a valid/ready output. It sits between requesting logic blocks and the single downstream consumer of the shared mux output.

## Interface

- WIDTH, default 1: data width of each requester's input word and of the output.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i high means requester i has data pending.
- d  input  8×WIDTH  data words, packed; d[i] belongs to requester i.
- grant  output  8  one-hot grant pulse to the selected requester.
- sel  output  3  current mux select, the index of the requester being served.
- y  output  WIDTH  registered mux output.
- out_valid  output  1  y holds a transferred word.
- out_ready  input  1  consumer accepts y.

## Operation

- States: IDLE, XFER, WAIT. Reset state is IDLE.
- Round-robin pointer ptr is 3 bits, reset 0.
- IDLE:
  - req == 0: stay in IDLE.
  - Otherwise pick the first index i with req[i]=1, searching circularly from ptr (ptr, ptr+1, …, 7, 0, …, ptr−1).
  - sel <= i, grant <= one-hot(i), next state XFER.
- XFER (exactly one cycle):
  - grant is high for this cycle only.
  - The mux datapath presents d[sel]; the block registers y <= d[sel] and sets out_valid <= 1.
  - Next state WAIT.
- WAIT:
  - out_valid=1; y and sel are held stable.
  - On out_ready=1: out_valid <= 0, ptr <= sel+1 (7 wraps to 0), next state IDLE.
  - Otherwise stay in WAIT.
- req is sampled only in IDLE.
  - Deassertion in XFER or WAIT has no effect on the in-flight transfer.
  - A requester that drops req before being sampled is not served.
- out_ready is ignored in IDLE and XFER.
- Each requester must hold d[i] stable from asserting req until it sees its grant pulse.
- Arithmetic: ptr and sel wrap modulo 8. The circular search uses 4-bit intermediate indices, truncated to 3 bits.

## Timing

- Reset values: grant=0, sel=0, y=0, out_valid=0, ptr=0, state IDLE.
- Reset asserted in any state returns the block to these values at the next edge. An in-flight word is discarded and no grant is issued.
- Latency: req sampled at edge N in IDLE, then grant high in cycle N+1 (XFER), then out_valid high from cycle N+2.
- Handshake: the transfer completes at the edge where out_valid=1 and out_ready=1. out_valid is low in the following cycle (IDLE).
- Maximum throughput is one word per 3 cycles with out_ready tied high. IDLE is always a one-cycle bubble.
- grant is never asserted while out_valid=1 for a previous word.
- Fairness: a continuously requesting requester is served within 8 transfers.

## Structure

- Shared package mux8_pkg holds:
  - the state enum: IDLE, XFER, WAIT;
  - NREQ=8 and SELW=3;
  - the function rr_pick(req, ptr), returning the selected index.
- Sub-module mux8_core: combinational 8:1 mux, WIDTH parameter, 3-bit select. The arbiter instantiates it once.
- The output register y and out_valid live in the arbiter, not in mux8_core.

## Test plan

- Reset: hold reset 2 cycles with req=8'hFF → grant=0, sel=0, y=0, out_valid=0. First grant after release goes to requester 0.
- Single request, WIDTH=1: req=8'b0010_0000, d[5]=1, out_ready=1 → grant=8'b0010_0000 for one cycle, sel=5, y=1 with out_valid two cycles after sampling, ptr becomes 6.
- Round robin with wrap: req=8'b1000_0011 held, out_ready=1 → serve order 0, 1, 7, 0. Each grant is one cycle wide, 3 cycles apart.
- Backpressure: one word pending, out_ready=0 for 5 cycles → out_valid, y and sel are stable and no new grant is issued. Raising out_ready completes the transfer; the next grant comes 2 cycles later.
- Request drop: requester 3 asserts req, then drops it during XFER → word d[3] still delivered and exactly one grant pulse issued.
- Reset mid-operation: reset asserted in WAIT with out_valid=1 → out_valid=0, ptr=0, state IDLE at the next edge. The discarded word is never accepted.
